// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline constants for the variable-latency hazard scoreboard.
// Register-index width, default longest latency and the per-unit latency codes.
package hazard_scoreboard_pkg;

    localparam int NUM_REGS_DEFAULT = 32;
    localparam int REG_IDX_W        = $clog2(NUM_REGS_DEFAULT);
    localparam int MAX_LAT_DEFAULT  = 8;

    localparam int LAT_ALU  = 1;
    localparam int LAT_LOAD = 2;
    localparam int LAT_FP   = MAX_LAT_DEFAULT;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

endpackage

// File: rtl/hazard_scoreboard_counter.sv
// sb_counter: one register's pending-writeback down-counter.
// A load beats a clear, so a new issue survives a flush of the same register.
module sb_counter #(
    parameter int CW = 4
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_load,
    input  logic          i_clear,
    input  logic [CW-1:0] i_load_val,
    output logic [CW-1:0] o_cnt
);

    logic [CW-1:0] r_cnt;

    // Counter state: reset, load, flush clear, else count down to idle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_scoreboard.sv
// Variable-latency RAW/WAW/writeback-port scoreboard for the decode stage.
// Register 0 is never tracked; the lowest pending index wins the wb_rd encode.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter  int NUM_REGS = NUM_REGS_DEFAULT,
    parameter  int MAX_LAT  = MAX_LAT_DEFAULT,
    localparam int CW       = $clog2(MAX_LAT + 2),
    localparam int RW       = $clog2(NUM_REGS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          issue_valid_d,
    input  logic [RW-1:0] rs1_d,
    input  logic [RW-1:0] rs2_d,
    input  logic          rs1_used_d,
    input  logic          rs2_used_d,
    input  logic [RW-1:0] rd_d,
    input  logic          rd_we_d,
    input  logic [CW-1:0] lat_d,
    input  logic          flush_e,
    output logic          stall_d,
    output logic          fwd_rs1_d,
    output logic          fwd_rs2_d,
    output logic          wb_valid,
    output logic [RW-1:0] wb_rd,
    output logic          busy
);

    logic [CW-1:0] w_cnt [NUM_REGS];
    logic [CW-1:0] w_lat_eff;
    logic          w_port_conflict;
    logic          w_busy;
    logic          w_wb_valid;
    logic [RW-1:0] w_wb_rd;
    logic          w_rs1_hit;
    logic          w_rs2_hit;
    logic          w_raw;
    logic          w_waw;
    logic          w_stall;
    logic          w_issue;
    logic          w_flush_hit;
    logic          r_last_valid;
    logic [RW-1:0] r_last_rd;

    assign w_cnt[0] = '0;

    for (genvar g = 1; g < NUM_REGS; g++) begin : g_cnt
        sb_counter #(.CW(CW)) u_cnt (
            .i_clk      (clk),
            .i_reset    (reset),
            .i_load     (w_issue && (rd_d == RW'(g))),
            .i_clear    (w_flush_hit && (r_last_rd == RW'(g))),
            .i_load_val (w_lat_eff),
            .o_cnt      (w_cnt[g])
        );
    end

    // Scan of all counters: port conflict, busy and the writeback encoder.
    always_comb begin
        w_lat_eff       = lat_d;
        w_port_conflict = 1'b0;
        w_busy          = 1'b0;
        w_wb_valid      = 1'b0;
        w_wb_rd         = '0;
        if ((lat_d == '0) || (lat_d > CW'(MAX_LAT))) begin
            w_lat_eff = CW'(MAX_LAT);
        end else begin
            w_lat_eff = lat_d;
        end
        for (int r = NUM_REGS - 1; r >= 1; r--) begin
            w_port_conflict = w_port_conflict | (w_cnt[r] == (w_lat_eff + CW'(1)));
            w_busy          = w_busy | (w_cnt[r] != '0);
            if (w_cnt[r] == CW'(1)) begin
                w_wb_valid = 1'b1;
                w_wb_rd    = RW'(r);
            end else begin
                w_wb_rd    = w_wb_rd;
            end
        end
    end

    // Decode-side hazard detection and the resulting issue strobe.
    always_comb begin
        w_rs1_hit   = rs1_used_d && (rs1_d != '0);
        w_rs2_hit   = rs2_used_d && (rs2_d != '0);
        w_raw       = (w_rs1_hit && (w_cnt[rs1_d] >= CW'(2))) ||
                      (w_rs2_hit && (w_cnt[rs2_d] >= CW'(2)));
        w_waw       = rd_we_d && (rd_d != '0) && (w_cnt[rd_d] >= CW'(2));
        w_stall     = issue_valid_d && (w_raw || w_waw || (rd_we_d && w_port_conflict));
        w_issue     = issue_valid_d && !w_stall && rd_we_d && (rd_d != '0);
        w_flush_hit = flush_e && r_last_valid;
    end

    // Last-issue record, valid only in the cycle right after its issue.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_valid <= 1'b0;
            r_last_rd    <= '0;
        end else begin
            r_last_valid <= w_issue;
            r_last_rd    <= rd_d;
        end
    end

    assign stall_d   = w_stall;
    assign fwd_rs1_d = w_rs1_hit && (w_cnt[rs1_d] == CW'(1));
    assign fwd_rs2_d = w_rs2_hit && (w_cnt[rs2_d] == CW'(1));
    assign wb_valid  = w_wb_valid;
    assign wb_rd     = w_wb_rd;
    assign busy      = w_busy;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: each cycle's hand-computed outputs are queued by the
// stimulus and checked by an independent negedge monitor.
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    localparam int CW = $clog2(MAX_LAT_DEFAULT + 2);

    logic           clk = 1'b0;
    logic           reset;
    logic           issue_valid_d;
    logic [4:0]     rs1_d, rs2_d, rd_d;
    logic           rs1_used_d, rs2_used_d, rd_we_d;
    logic [CW-1:0]  lat_d;
    logic           flush_e;
    logic           stall_d, fwd_rs1_d, fwd_rs2_d, wb_valid, busy;
    logic [4:0]     wb_rd;

    typedef struct {
        logic st;
        logic f1;
        logic f2;
        logic wv;
        int   wr;
        logic bz;
        int   cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   cyc_no = 0;

    hazard_scoreboard dut (
        .clk           (clk),
        .reset         (reset),
        .issue_valid_d (issue_valid_d),
        .rs1_d         (rs1_d),
        .rs2_d         (rs2_d),
        .rs1_used_d    (rs1_used_d),
        .rs2_used_d    (rs2_used_d),
        .rd_d          (rd_d),
        .rd_we_d       (rd_we_d),
        .lat_d         (lat_d),
        .flush_e       (flush_e),
        .stall_d       (stall_d),
        .fwd_rs1_d     (fwd_rs1_d),
        .fwd_rs2_d     (fwd_rs2_d),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int cyc, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s at step %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    // Monitor: pop the expectation for this cycle and compare all outputs.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("stall_d",   e.cyc, int'(stall_d),   int'(e.st));
            chk("fwd_rs1_d", e.cyc, int'(fwd_rs1_d), int'(e.f1));
            chk("fwd_rs2_d", e.cyc, int'(fwd_rs2_d), int'(e.f2));
            chk("wb_valid",  e.cyc, int'(wb_valid),  int'(e.wv));
            chk("wb_rd",     e.cyc, int'(wb_rd),     e.wr);
            chk("busy",      e.cyc, int'(busy),      int'(e.bz));
        end
    end

    task automatic cyc(input logic iv, input int rs1, input logic u1, input int rs2,
                       input logic u2, input int rd, input logic we, input int lat,
                       input logic fl, input logic rst,
                       input logic e_st, input logic e_f1, input logic e_f2,
                       input logic e_wv, input int e_wr, input logic e_bz);
        exp_t e;
        issue_valid_d = iv;
        rs1_d         = 5'(rs1);
        rs1_used_d    = u1;
        rs2_d         = 5'(rs2);
        rs2_used_d    = u2;
        rd_d          = 5'(rd);
        rd_we_d       = we;
        lat_d         = CW'(lat);
        flush_e       = fl;
        reset         = rst;
        e.st = e_st; e.f1 = e_f1; e.f2 = e_f2; e.wv = e_wv; e.wr = e_wr; e.bz = e_bz;
        e.cyc = cyc_no;
        exp_q.push_back(e);
        cyc_no++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic e_wv, input int e_wr, input logic e_bz);
        cyc(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, LAT_ALU, 1'b0, 1'b0,
            1'b0, 1'b0, 1'b0, e_wv, e_wr, e_bz);
    endtask

    initial begin
        reset = 1'b1; issue_valid_d = 1'b0; rs1_d = '0; rs2_d = '0; rd_d = '0;
        rs1_used_d = 1'b0; rs2_used_d = 1'b0; rd_we_d = 1'b0; lat_d = CW'(1); flush_e = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // RAW: rd=5 lat=3 issued straight out of reset, x5 consumer stalls then forwards
        cyc(1, 0, 0, 0, 0, 5, 1, 3,       0, 0,  0, 0, 0, 0, 0, 0);
        cyc(1, 5, 1, 0, 0, 6, 1, LAT_ALU, 0, 0,  1, 0, 0, 0, 0, 1);
        cyc(1, 5, 1, 0, 0, 6, 1, LAT_ALU, 0, 0,  1, 0, 0, 0, 0, 1);
        cyc(1, 5, 1, 0, 0, 6, 1, LAT_ALU, 0, 0,  0, 1, 0, 1, 5, 1);
        idle(1, 6, 1);
        idle(0, 0, 0);

        // Writeback port conflict, then retry; x7 bypassed on rs2
        cyc(1, 0, 0, 0, 0, 7, 1, 4,       0, 0,  0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 8, 1, 3,       0, 0,  1, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 8, 1, 3,       0, 0,  0, 0, 0, 0, 0, 1);
        idle(0, 0, 1);
        cyc(1, 0, 0, 7, 1, 0, 0, LAT_ALU, 0, 0,  0, 0, 1, 1, 7, 1);
        idle(1, 8, 1);
        idle(0, 0, 0);

        // Flush of rd=3 lat=2, then flush racing a same-rd issue
        cyc(1, 0, 0, 0, 0, 3, 1, LAT_LOAD, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, LAT_ALU,  1, 0, 0, 0, 0, 0, 0, 1);
        cyc(1, 3, 1, 0, 0, 0, 0, LAT_ALU,  0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, LAT_ALU,  1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 3, 1, LAT_ALU,  0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 3, 1, LAT_LOAD, 1, 0, 0, 0, 0, 1, 3, 1);
        idle(0, 0, 1);
        idle(1, 3, 1);
        idle(0, 0, 0);

        // Register 0 is never tracked
        cyc(1, 0, 1, 0, 1, 0, 1, 5,       0, 0,  0, 0, 0, 0, 0, 0);
        idle(0, 0, 0);

        // Mid-flight reset of rd=9 lat=MAX_LAT; the issue during reset is ignored
        cyc(1, 0, 0, 0, 0, 9, 1, LAT_FP,  0, 0,  0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 10, 1, LAT_ALU, 0, 1, 0, 0, 0, 0, 0, 1);
        cyc(1, 9, 1, 0, 0, 0, 0, LAT_ALU, 0, 0,  0, 0, 0, 0, 0, 0);
        repeat (8) idle(0, 0, 0);

        // WAW: rd=4 lat=6 blocks a rd=4 lat=1 rewrite until cnt[4]==1
        cyc(1, 0, 0, 0, 0, 4, 1, 6,       0, 0,  0, 0, 0, 0, 0, 0);
        repeat (5) cyc(1, 0, 0, 0, 0, 4, 1, LAT_ALU, 0, 0, 1, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 4, 1, LAT_ALU, 0, 0,  0, 0, 0, 1, 4, 1);
        idle(1, 4, 1);
        idle(0, 0, 0);

        @(posedge clk);
        #1;
        chk("queue_drained", cyc_no, exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
